block_swing_ctrl: RTL and testbench

Consumer of the frame-rate tick produced by the game speed counter. Moves the active block horizontally one STEP per tick, bouncing between the left edge (x = 0) and the right edge (x + width = X_MAX). When the player presses drop, it freezes the block position and hands it to the stacking logic over a valid/ack handshake. Sits between the speed counter and the stack/VGA draw logic.

---
 rtl/block_swing_ctrl_if.sv | 26 ++
 rtl/block_swing_ctrl.sv | 133 +++++++++++++
 tb/tb_block_swing_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/block_swing_ctrl_if.sv
// Handshake and position bus between the swing controller, the speed counter
// and the stack/draw logic.
interface block_swing_ctrl_if #(
  parameter int X_W = 8
);
  logic           tick;
  logic           start;
  logic [X_W-1:0] blk_width;
  logic           drop;
  logic           drop_ack;
  logic [X_W-1:0] x_pos;
  logic           dir;
  logic           swinging;
  logic           drop_valid;
  logic [X_W-1:0] drop_x;

  modport master (
    output tick, start, blk_width, drop, drop_ack,
    input  x_pos, dir, swinging, drop_valid, drop_x
  );

  modport slave (
    input  tick, start, blk_width, drop, drop_ack,
    output x_pos, dir, swinging, drop_valid, drop_x
  );
endinterface

// File: rtl/block_swing_ctrl.sv
// Swings the active block left/right one STEP per tick between the playfield
// edges and hands the frozen position to the stacking logic on drop.
module block_swing_ctrl #(
  parameter int X_W   = 8,
  parameter int X_MAX = 160,
  parameter int STEP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  block_swing_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWING = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [X_W:0] STEP_C     = (X_W+1)'(STEP);
  localparam logic [X_W:0] XMAX_C     = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] LEFT_LIM_C = STEP_C + (X_W+1)'(1);

  state_t         state_r, state_nxt_s;
  logic [X_W-1:0] x_pos_r, x_pos_nxt_s;
  logic [X_W-1:0] drop_x_r, drop_x_nxt_s;
  logic [X_W-1:0] width_r, width_nxt_s;
  logic           dir_r, dir_nxt_s;
  logic           swinging_r;
  logic           drop_valid_r;

  logic [X_W:0]   reach_s;
  logic [X_W-1:0] clamp_s;
  logic           degen_s;

  // Extra bit keeps x + STEP + width from wrapping before the edge compare.
  assign reach_s = {1'b0, x_pos_r} + STEP_C + {1'b0, width_r};
  assign clamp_s = XMAX_C[X_W-1:0] - width_r;
  assign degen_s = ({1'b0, width_r} >= XMAX_C);

  // Next-state and next-value logic for position, direction and handshake.
  always_comb begin
    state_nxt_s  = state_r;
    x_pos_nxt_s  = x_pos_r;
    dir_nxt_s    = dir_r;
    drop_x_nxt_s = drop_x_r;
    width_nxt_s  = width_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = SWING;
          x_pos_nxt_s = {X_W{1'b0}};
          dir_nxt_s   = 1'b1;
          width_nxt_s = bus.blk_width;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWING: begin
        if (bus.drop) begin
          // Freeze the pre-tick position; a coincident tick is dropped.
          state_nxt_s  = HOLD;
          drop_x_nxt_s = x_pos_r;
        end else if (bus.tick) begin
          if (degen_s) begin
            x_pos_nxt_s = {X_W{1'b0}};
            dir_nxt_s   = 1'b1;
          end else if (dir_r) begin
            if (reach_s > XMAX_C) begin
              x_pos_nxt_s = clamp_s;
              dir_nxt_s   = 1'b0;
            end else begin
              x_pos_nxt_s = x_pos_r + STEP_C[X_W-1:0];
            end
          end else begin
            if ({1'b0, x_pos_r} < LEFT_LIM_C) begin
              x_pos_nxt_s = {X_W{1'b0}};
              dir_nxt_s   = 1'b1;
            end else begin
              x_pos_nxt_s = x_pos_r - STEP_C[X_W-1:0];
            end
          end
        end else begin
          state_nxt_s = SWING;
        end
      end
      HOLD: begin
        if (bus.drop_ack) begin
          if (bus.start) begin
            state_nxt_s = SWING;
            x_pos_nxt_s = {X_W{1'b0}};
            dir_nxt_s   = 1'b1;
            width_nxt_s = bus.blk_width;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      x_pos_r      <= {X_W{1'b0}};
      dir_r        <= 1'b1;
      drop_x_r     <= {X_W{1'b0}};
      width_r      <= {X_W{1'b0}};
      swinging_r   <= 1'b0;
      drop_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      x_pos_r      <= x_pos_nxt_s;
      dir_r        <= dir_nxt_s;
      drop_x_r     <= drop_x_nxt_s;
      width_r      <= width_nxt_s;
      swinging_r   <= (state_nxt_s == SWING);
      drop_valid_r <= (state_nxt_s == HOLD);
    end
  end

  assign bus.x_pos      = x_pos_r;
  assign bus.dir        = dir_r;
  assign bus.swinging   = swinging_r;
  assign bus.drop_valid = drop_valid_r;
  assign bus.drop_x     = drop_x_r;

endmodule

// File: tb/tb_block_swing_ctrl.sv
// Directed self-checking bench for block_swing_ctrl (X_W=8, X_MAX=160, STEP=2).
module tb_block_swing_ctrl;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  block_swing_ctrl_if #(.X_W(8)) bus ();

  block_swing_ctrl #(.X_W(8), .X_MAX(160), .STEP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
    end
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total_cnt++; if (bus.x_pos !== 8'd0) $display("FAIL reset_x: got %0d exp 0", bus.x_pos); else pass_cnt++;
    total_cnt++; if (bus.dir !== 1'b1) $display("FAIL reset_dir: got %0d exp 1", bus.dir); else pass_cnt++;
    total_cnt++; if (bus.swinging !== 1'b0) $display("FAIL reset_swinging: got %0d exp 0", bus.swinging); else pass_cnt++;
    total_cnt++; if (bus.drop_valid !== 1'b0) $display("FAIL reset_dv: got %0d exp 0", bus.drop_valid); else pass_cnt++;
    total_cnt++; if (bus.drop_x !== 8'd0) $display("FAIL reset_dx: got %0d exp 0", bus.drop_x); else pass_cnt++;
    // tick in IDLE must not move anything
    do_ticks(2);
    total_cnt++; if (bus.x_pos !== 8'd0 || bus.swinging !== 1'b0) $display("FAIL idle_tick: got x=%0d sw=%0d exp x=0 sw=0", bus.x_pos, bus.swinging); else pass_cnt++;
  endtask

  task automatic test_swing();
    bus.start     = 1'b1;
    bus.blk_width = 8'd20;
    step();
    bus.start = 1'b0;
    total_cnt++; if (bus.swinging !== 1'b1 || bus.x_pos !== 8'd0) $display("FAIL start_enter: got sw=%0d x=%0d exp sw=1 x=0", bus.swinging, bus.x_pos); else pass_cnt++;
    do_ticks(5);
    total_cnt++; if (bus.x_pos !== 8'd10) $display("FAIL swing5_x: got %0d exp 10", bus.x_pos); else pass_cnt++;
    total_cnt++; if (bus.dir !== 1'b1 || bus.swinging !== 1'b1) $display("FAIL swing5_flags: got dir=%0d sw=%0d exp 1 1", bus.dir, bus.swinging); else pass_cnt++;
  endtask

  task automatic test_right_bounce();
    do_ticks(64);
    total_cnt++; if (bus.x_pos !== 8'd138) $display("FAIL right_138: got %0d exp 138", bus.x_pos); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd140 || bus.dir !== 1'b1) $display("FAIL right_140: got x=%0d dir=%0d exp x=140 dir=1", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd140 || bus.dir !== 1'b0) $display("FAIL right_clamp: got x=%0d dir=%0d exp x=140 dir=0", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd138 || bus.dir !== 1'b0) $display("FAIL right_back: got x=%0d dir=%0d exp x=138 dir=0", bus.x_pos, bus.dir); else pass_cnt++;
  endtask

  task automatic test_left_bounce();
    do_ticks(68);
    total_cnt++; if (bus.x_pos !== 8'd2 || bus.dir !== 1'b0) $display("FAIL left_2: got x=%0d dir=%0d exp x=2 dir=0", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd0 || bus.dir !== 1'b1) $display("FAIL left_edge: got x=%0d dir=%0d exp x=0 dir=1", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd2 || bus.dir !== 1'b1) $display("FAIL left_out: got x=%0d dir=%0d exp x=2 dir=1", bus.x_pos, bus.dir); else pass_cnt++;
  endtask

  task automatic test_drop();
    do_ticks(24);
    total_cnt++; if (bus.x_pos !== 8'd50) $display("FAIL drop_pre: got %0d exp 50", bus.x_pos); else pass_cnt++;
    bus.drop = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.drop = 1'b0;
    bus.tick = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b1 || bus.swinging !== 1'b0) $display("FAIL drop_hold: got dv=%0d sw=%0d exp dv=1 sw=0", bus.drop_valid, bus.swinging); else pass_cnt++;
    total_cnt++; if (bus.drop_x !== 8'd50 || bus.x_pos !== 8'd50) $display("FAIL drop_x: got dx=%0d x=%0d exp 50 50", bus.drop_x, bus.x_pos); else pass_cnt++;
    do_ticks(3);
    total_cnt++; if (bus.drop_x !== 8'd50 || bus.x_pos !== 8'd50 || bus.drop_valid !== 1'b1) $display("FAIL hold_frozen: got dx=%0d x=%0d dv=%0d exp 50 50 1", bus.drop_x, bus.x_pos, bus.drop_valid); else pass_cnt++;
    bus.drop_ack = 1'b1;
    step();
    bus.drop_ack = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b0 || bus.swinging !== 1'b0) $display("FAIL ack_idle: got dv=%0d sw=%0d exp 0 0", bus.drop_valid, bus.swinging); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.start     = 1'b1;
    bus.blk_width = 8'd30;
    step();
    bus.start = 1'b0;
    do_ticks(5);
    bus.drop = 1'b1;
    step();
    bus.drop = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b1 || bus.drop_x !== 8'd10) $display("FAIL b2b_hold: got dv=%0d dx=%0d exp 1 10", bus.drop_valid, bus.drop_x); else pass_cnt++;
    bus.start     = 1'b1;
    bus.drop_ack  = 1'b1;
    bus.blk_width = 8'd30;
    step();
    bus.start    = 1'b0;
    bus.drop_ack = 1'b0;
    total_cnt++; if (bus.swinging !== 1'b1 || bus.drop_valid !== 1'b0) $display("FAIL b2b_state: got sw=%0d dv=%0d exp 1 0", bus.swinging, bus.drop_valid); else pass_cnt++;
    total_cnt++; if (bus.x_pos !== 8'd0 || bus.dir !== 1'b1) $display("FAIL b2b_pos: got x=%0d dir=%0d exp 0 1", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd2) $display("FAIL b2b_move: got %0d exp 2", bus.x_pos); else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    do_ticks(39);
    bus.drop = 1'b1;
    step();
    bus.drop = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b1 || bus.drop_x !== 8'd80) $display("FAIL rh_hold: got dv=%0d dx=%0d exp 1 80", bus.drop_valid, bus.drop_x); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (bus.x_pos !== 8'd0 || bus.drop_x !== 8'd0) $display("FAIL rh_pos: got x=%0d dx=%0d exp 0 0", bus.x_pos, bus.drop_x); else pass_cnt++;
    total_cnt++; if (bus.dir !== 1'b1 || bus.swinging !== 1'b0 || bus.drop_valid !== 1'b0) $display("FAIL rh_flags: got dir=%0d sw=%0d dv=%0d exp 1 0 0", bus.dir, bus.swinging, bus.drop_valid); else pass_cnt++;
    bus.drop_ack = 1'b1;
    bus.drop     = 1'b1;
    step();
    bus.drop_ack = 1'b0;
    bus.drop     = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b0 || bus.swinging !== 1'b0) $display("FAIL idle_ignore: got dv=%0d sw=%0d exp 0 0", bus.drop_valid, bus.swinging); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    bus.start     = 1'b1;
    bus.blk_width = 8'd200;
    step();
    bus.start = 1'b0;
    do_ticks(3);
    total_cnt++; if (bus.x_pos !== 8'd0 || bus.dir !== 1'b1 || bus.swinging !== 1'b1) $display("FAIL wide_still: got x=%0d dir=%0d sw=%0d exp 0 1 1", bus.x_pos, bus.dir, bus.swinging); else pass_cnt++;
    bus.drop = 1'b1;
    step();
    bus.drop = 1'b0;
    total_cnt++; if (bus.drop_valid !== 1'b1 || bus.drop_x !== 8'd0) $display("FAIL wide_drop: got dv=%0d dx=%0d exp 1 0", bus.drop_valid, bus.drop_x); else pass_cnt++;
    // Zero width runs all the way to X_MAX; a start mid-swing is ignored.
    bus.start     = 1'b1;
    bus.drop_ack  = 1'b1;
    bus.blk_width = 8'd0;
    step();
    bus.drop_ack  = 1'b0;
    bus.blk_width = 8'd50;
    bus.tick      = 1'b1;
    step();
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    total_cnt++; if (bus.x_pos !== 8'd2) $display("FAIL start_in_swing: got %0d exp 2", bus.x_pos); else pass_cnt++;
    do_ticks(79);
    total_cnt++; if (bus.x_pos !== 8'd160 || bus.dir !== 1'b1) $display("FAIL zero_edge: got x=%0d dir=%0d exp 160 1", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd160 || bus.dir !== 1'b0) $display("FAIL zero_dwell: got x=%0d dir=%0d exp 160 0", bus.x_pos, bus.dir); else pass_cnt++;
    do_ticks(1);
    total_cnt++; if (bus.x_pos !== 8'd158) $display("FAIL zero_back: got %0d exp 158", bus.x_pos); else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b1;
    bus.tick      = 1'b0;
    bus.start     = 1'b0;
    bus.blk_width = 8'd0;
    bus.drop      = 1'b0;
    bus.drop_ack  = 1'b0;
    test_reset();
    test_swing();
    test_right_bounce();
    test_left_bounce();
    test_drop();
    test_back_to_back();
    test_reset_in_hold();
    test_degenerate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
